verin_adc_acq: RTL and testbench

Serial acquisition front-end for the actuator (vérin) position sensor. Drives an 8-bit ADC0831-style serial converter (chip select, generated ADC clock, serial data in) and delivers each conversion as a parallel byte with a one-cycle valid strobe and end-stop flags. It sits directly upstream of the actuator Avalon component, whose `cs`, `clk_adc` and `data_in` pins it owns; the component's register file and PWM/direction logic consume `data`, `data_valid`, `at_min` and `at_max`.

---
 rtl/verin_pkg.sv | 21 ++
 rtl/verin_adc_tick.sv | 41 ++++
 rtl/verin_adc_acq.sv | 139 +++++++++++++
 tb/tb_verin_adc_acq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/verin_pkg.sv
`default_nettype none
// ============================================================================
// Module   : verin_pkg
// Brief    : Shared constants and state encoding for the verin ADC front-end.
// Revision : 1.0
// ============================================================================
package verin_pkg;

    localparam int ADC_BITS    = 8;
    localparam int ADC_CLOCKS  = 9;
    localparam int DIV_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CS_SETUP = 2'd1,
        CLOCKING = 2'd2,
        DONE     = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/verin_adc_tick.sv
`default_nettype none
// ============================================================================
// Module   : verin_adc_tick
// Brief    : Free-running DIV prescaler; tick on count DIV-1, clearable.
// Revision : 1.0
// ============================================================================
module verin_adc_tick
    import verin_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(DIV);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = (cnt_q == CNT_W'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/verin_adc_acq.sv
`default_nettype none
// ============================================================================
// Module   : verin_adc_acq
// Brief    : ADC0831-style serial acquisition with parallel result and limits.
// Revision : 1.0
// ============================================================================
module verin_adc_acq
    import verin_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                auto,
    input  logic [ADC_BITS-1:0] lim_min,
    input  logic [ADC_BITS-1:0] lim_max,
    input  logic                data_in,
    output logic                cs_n,
    output logic                clk_adc,
    output logic                busy,
    output logic [ADC_BITS-1:0] data,
    output logic                data_valid,
    output logic                at_min,
    output logic                at_max
);

    localparam int CLK_CNT_W = $clog2(ADC_CLOCKS);

    state_t                state_q;
    logic [1:0]            sync_q;
    logic [CLK_CNT_W-1:0]  clk_cnt_q;
    logic [ADC_BITS-1:0]   shift_q;
    logic [ADC_BITS-1:0]   shift_d;
    logic [ADC_BITS-1:0]   data_q;
    logic                  cs_n_q;
    logic                  clk_adc_q;
    logic                  busy_q;
    logic                  valid_q;
    logic                  at_min_q;
    logic                  at_max_q;

    logic                  accept;
    logic                  tick;
    logic                  last_clock;

    assign accept     = (state_q == IDLE) && (start || auto);
    assign last_clock = (clk_cnt_q == CLK_CNT_W'(ADC_CLOCKS - 1));
    assign shift_d    = {shift_q[ADC_BITS-2:0], sync_q[1]};

    verin_adc_tick #(
        .DIV     (DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (accept),
        .tick_o  (tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], data_in};
        end
    end

    // clk_adc_q doubles as the half-phase flag: 1 = high half of an ADC clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cs_n_q    <= 1'b1;
            clk_adc_q <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            at_min_q  <= 1'b0;
            at_max_q  <= 1'b0;
            clk_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= CS_SETUP;
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                CS_SETUP: begin
                    if (tick) begin
                        state_q   <= CLOCKING;
                        clk_adc_q <= 1'b1;
                        clk_cnt_q <= '0;
                    end
                end
                CLOCKING: begin
                    if (tick) begin
                        if (clk_adc_q) begin
                            clk_adc_q <= 1'b0;
                        end else if (last_clock) begin
                            state_q  <= DONE;
                            cs_n_q   <= 1'b1;
                            data_q   <= shift_q;
                            valid_q  <= 1'b1;
                            at_min_q <= (shift_q <= lim_min);
                            at_max_q <= (shift_q >= lim_max);
                        end else begin
                            // Rising edge of clocks 2..9: one data bit, MSB first.
                            clk_adc_q <= 1'b1;
                            clk_cnt_q <= clk_cnt_q + 1'b1;
                            shift_q   <= shift_d;
                        end
                    end
                end
                DONE: begin
                    if (tick) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cs_n       = cs_n_q;
    assign clk_adc    = clk_adc_q;
    assign busy       = busy_q;
    assign data       = data_q;
    assign data_valid = valid_q;
    assign at_min     = at_min_q;
    assign at_max     = at_max_q;

endmodule
`default_nettype wire

// File: tb/tb_verin_adc_acq.sv
`default_nettype none
// ============================================================================
// Module   : tb_verin_adc_acq
// Brief    : Directed self-checking bench for verin_adc_acq with DIV=4.
// Revision : 1.0
// ============================================================================
module tb_verin_adc_acq;

    localparam int DIV = 4;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       start   = 1'b0;
    logic       auto    = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] lim_min = 8'h00;
    logic [7:0] lim_max = 8'hFF;
    logic       cs_n;
    logic       clk_adc;
    logic       busy;
    logic [7:0] data;
    logic       data_valid;
    logic       at_min;
    logic       at_max;

    int total = 0;
    int bad   = 0;

    verin_adc_acq #(
        .DIV        (DIV)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .auto       (auto),
        .lim_min    (lim_min),
        .lim_max    (lim_max),
        .data_in    (data_in),
        .cs_n       (cs_n),
        .clk_adc    (clk_adc),
        .busy       (busy),
        .data       (data),
        .data_valid (data_valid),
        .at_min     (at_min),
        .at_max     (at_max)
    );

    always #5 clk = ~clk;

    // ADC model: word chosen when cs_n falls, bit 7..0 driven on clk_adc falls 1..8.
    logic [7:0] adc_seq [0:2];
    int         seq_len  = 1;
    int         seq_pos  = 0;
    int         adc_idx  = 0;
    logic [7:0] cur_word = 8'h00;
    logic       last_clk = 1'b0;
    logic       last_cs  = 1'b1;

    always @(clk_adc or cs_n) begin
        if (cs_n) begin
            adc_idx = 0;
        end else if (last_cs) begin
            cur_word = adc_seq[seq_pos];
            seq_pos  = (seq_pos + 1) % seq_len;
            adc_idx  = 0;
        end else if (last_clk && !clk_adc) begin
            if (adc_idx < 8) data_in = cur_word[7 - adc_idx];
            adc_idx++;
        end
        last_clk = clk_adc;
        last_cs  = cs_n;
    end

    // Per-conversion observations, indexed in cycles after E0.
    int         first_rise, n_pulses, hi_min, hi_max, valid_cnt, valid_at;
    int         busy_fall, cs_rise, cs_fall2;
    logic [7:0] valid_data;
    logic       valid_min, valid_max, cs0, busy0;

    task automatic begin_conv(input logic [7:0] w);
        adc_seq[0] = w;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic watch(input int ncyc, input int restart_at);
        int   hi_len = 0;
        logic pclk   = 1'b0;
        logic pcs    = 1'b0;
        logic pbusy  = 1'b1;
        first_rise = -1; n_pulses = 0; hi_min = 999; hi_max = 0;
        valid_cnt = 0; valid_at = -1; busy_fall = -1; cs_rise = -1; cs_fall2 = -1;
        valid_data = 8'h00; valid_min = 1'b0; valid_max = 1'b0;
        cs0 = cs_n; busy0 = busy;
        for (int n = 0; n < ncyc; n++) begin
            if (clk_adc && !pclk) begin
                n_pulses++;
                if (first_rise < 0) first_rise = n;
                hi_len = 0;
            end
            if (clk_adc) hi_len++;
            if (!clk_adc && pclk) begin
                if (hi_len < hi_min) hi_min = hi_len;
                if (hi_len > hi_max) hi_max = hi_len;
            end
            if (data_valid) begin
                valid_cnt++; valid_at = n; valid_data = data;
                valid_min = at_min; valid_max = at_max;
            end
            if (!busy && pbusy && busy_fall < 0) busy_fall = n;
            if (cs_n && !pcs && cs_rise < 0) cs_rise = n;
            if (!cs_n && pcs) cs_fall2 = n;
            pclk = clk_adc; pcs = cs_n; pbusy = busy;
            if (n == restart_at - 1) start = 1'b1;
            if (n == restart_at) start = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int idle_bad = 0;
        @(negedge clk);
        total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
        total++; if (clk_adc !== 1'b0) begin bad++; $display("FAIL reset_clk_adc: got %b want 0", clk_adc); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data); end
        total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", data_valid); end
        total++; if ({at_min, at_max} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {at_min, at_max}); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cs_n !== 1'b1 || clk_adc !== 1'b0 || busy !== 1'b0 || data !== 8'h00 || data_valid !== 1'b0)
                idle_bad++;
        end
        total++; if (idle_bad !== 0) begin bad++; $display("FAIL idle_quiet: got %0d bad cycles want 0", idle_bad); end
    endtask

    task automatic test_single;
        begin_conv(8'hA5);
        watch(100, -1);
        total++; if (cs0 !== 1'b0) begin bad++; $display("FAIL a5_cs_low_e0: got %b want 0", cs0); end
        total++; if (busy0 !== 1'b1) begin bad++; $display("FAIL a5_busy_e0: got %b want 1", busy0); end
        total++; if (first_rise !== 4) begin bad++; $display("FAIL a5_first_rise: got %0d want 4", first_rise); end
        total++; if (n_pulses !== 9) begin bad++; $display("FAIL a5_pulses: got %0d want 9", n_pulses); end
        total++; if (hi_min !== 4 || hi_max !== 4) begin bad++; $display("FAIL a5_high_len: got %0d..%0d want 4..4", hi_min, hi_max); end
        total++; if (valid_cnt !== 1) begin bad++; $display("FAIL a5_valid_cnt: got %0d want 1", valid_cnt); end
        total++; if (valid_at !== 76) begin bad++; $display("FAIL a5_valid_at: got %0d want 76", valid_at); end
        total++; if (valid_data !== 8'hA5) begin bad++; $display("FAIL a5_data: got %h want a5", valid_data); end
        total++; if (cs_rise !== 76) begin bad++; $display("FAIL a5_cs_rise: got %0d want 76", cs_rise); end
        total++; if (busy_fall !== 80) begin bad++; $display("FAIL a5_busy_fall: got %0d want 80", busy_fall); end
        total++; if (data !== 8'hA5) begin bad++; $display("FAIL a5_data_hold: got %h want a5", data); end
    endtask

    task automatic test_limits;
        lim_min = 8'h10;
        lim_max = 8'hF0;
        for (int i = 0; i < 3; i++) begin
            logic [7:0] w;
            logic       emin, emax;
            case (i)
                0:       begin w = 8'h10; emin = 1'b1; emax = 1'b0; end
                1:       begin w = 8'hF5; emin = 1'b0; emax = 1'b1; end
                default: begin w = 8'h80; emin = 1'b0; emax = 1'b0; end
            endcase
            begin_conv(w);
            watch(90, -1);
            total++; if (valid_data !== w) begin bad++; $display("FAIL lim_data_%0d: got %h want %h", i, valid_data, w); end
            total++; if (valid_min !== emin) begin bad++; $display("FAIL lim_at_min_%0d: got %b want %b", i, valid_min, emin); end
            total++; if (valid_max !== emax) begin bad++; $display("FAIL lim_at_max_%0d: got %b want %b", i, valid_max, emax); end
        end
        lim_min = 8'hFF;
        lim_max = 8'h00;
        repeat (10) @(negedge clk);
        total++; if ({at_min, at_max} !== 2'b00) begin bad++; $display("FAIL lim_hold: got %b want 00", {at_min, at_max}); end
        begin_conv(8'h80);
        watch(90, -1);
        total++; if ({valid_min, valid_max} !== 2'b11) begin bad++; $display("FAIL lim_inverted: got %b want 11", {valid_min, valid_max}); end
        lim_min = 8'h00;
        lim_max = 8'hFF;
    endtask

    task automatic test_auto;
        int         vt [0:2];
        logic [7:0] vd [0:2];
        int         nv = 0;
        adc_seq[0] = 8'h00; adc_seq[1] = 8'hFF; adc_seq[2] = 8'h5A;
        seq_len = 3;
        auto = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 300; n++) begin
            if (data_valid && nv < 3) begin
                vt[nv] = n; vd[nv] = data; nv++;
                if (nv == 3) auto = 1'b0;
            end
            @(negedge clk);
        end
        auto = 1'b0;
        seq_len = 1;
        total++; if (nv !== 3) begin bad++; $display("FAIL auto_strobes: got %0d want 3", nv); end
        if (nv == 3) begin
            total++; if (vt[0] !== 76) begin bad++; $display("FAIL auto_first_at: got %0d want 76", vt[0]); end
            total++; if (vt[1] - vt[0] !== 81) begin bad++; $display("FAIL auto_gap1: got %0d want 81", vt[1] - vt[0]); end
            total++; if (vt[2] - vt[1] !== 81) begin bad++; $display("FAIL auto_gap2: got %0d want 81", vt[2] - vt[1]); end
            total++; if (vd[0] !== 8'h00) begin bad++; $display("FAIL auto_data0: got %h want 00", vd[0]); end
            total++; if (vd[1] !== 8'hFF) begin bad++; $display("FAIL auto_data1: got %h want ff", vd[1]); end
            total++; if (vd[2] !== 8'h5A) begin bad++; $display("FAIL auto_data2: got %h want 5a", vd[2]); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL auto_stop_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        begin_conv(8'h3C);
        watch(100, 30);
        total++; if (valid_cnt !== 1) begin bad++; $display("FAIL rep_valid_cnt: got %0d want 1", valid_cnt); end
        total++; if (valid_at !== 76) begin bad++; $display("FAIL rep_valid_at: got %0d want 76", valid_at); end
        total++; if (valid_data !== 8'h3C) begin bad++; $display("FAIL rep_data: got %h want 3c", valid_data); end
        total++; if (n_pulses !== 9) begin bad++; $display("FAIL rep_pulses: got %0d want 9", n_pulses); end
        total++; if (busy_fall !== 80) begin bad++; $display("FAIL rep_busy_fall: got %0d want 80", busy_fall); end
        total++; if (cs_fall2 !== -1) begin bad++; $display("FAIL rep_extra_conv: got cs_n fall at %0d want none", cs_fall2); end
    endtask

    task automatic test_mid_reset;
        begin_conv(8'hC3);
        repeat (39) @(negedge clk);
        total++; if (clk_adc !== 1'b1) begin bad++; $display("FAIL mr_pre_clk_adc: got %b want 1", clk_adc); end
        reset_n = 1'b0;
        #1;
        total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL mr_cs_n: got %b want 1", cs_n); end
        total++; if (clk_adc !== 1'b0) begin bad++; $display("FAIL mr_clk_adc: got %b want 0", clk_adc); end
        total++; if (data !== 8'h00) begin bad++; $display("FAIL mr_data: got %h want 00", data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mr_busy: got %b want 0", busy); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        begin_conv(8'h96);
        watch(100, -1);
        total++; if (valid_data !== 8'h96) begin bad++; $display("FAIL mr_after_data: got %h want 96", valid_data); end
        total++; if (valid_at !== 76) begin bad++; $display("FAIL mr_after_valid_at: got %0d want 76", valid_at); end
        total++; if (n_pulses !== 9) begin bad++; $display("FAIL mr_after_pulses: got %0d want 9", n_pulses); end
    endtask

    initial begin
        adc_seq[0] = 8'h00; adc_seq[1] = 8'h00; adc_seq[2] = 8'h00;
        test_reset();
        test_single();
        test_limits();
        test_auto();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
